// File: rtl/life_step_engine.sv
// life_step_engine
// Game-of-Life (B3/S23) next-state engine over a W x H toroidal grid.
// The grid is loaded one row per handshake. A start request then runs
// step_n generations, updating one row per clock.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   load_valid : load_row is valid
//   load_ready : a load row is accepted this cycle (not while running)
//   load_row   : row data, bit c = column c, rows delivered 0..H-1
//   start      : single-cycle run request (honoured in IDLE only)
//   step_n     : generations to run, sampled with start
//   busy       : high while generations are being computed
//   done       : one-cycle pulse when a run completes
//   gen        : generations computed since the last load
//   still      : last completed generation changed no cell
//   grid       : current grid, row r = grid[r*W +: W]
module life_step_engine #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int GW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [W-1:0]    load_row,
  input  logic            start,
  input  logic [GW-1:0]   step_n,
  output logic            busy,
  output logic            done,
  output logic [GW-1:0]   gen,
  output logic            still,
  output logic [W*H-1:0]  grid
);

  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_ROW = IW'(H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Next value of one row given the old rows above, at and below it.
  // Columns wrap around the torus edges.
  function automatic logic [W-1:0] life_row(input logic [W-1:0] above,
                                            input logic [W-1:0] cur,
                                            input logic [W-1:0] below);
    logic [3:0]    n;
    logic [CW-1:0] cl;
    logic [CW-1:0] cc;
    logic [CW-1:0] cr;
    life_row = '0;
    for (int c = 0; c < W; c++) begin
      cc = CW'(c);
      cl = (c == 0)     ? CW'(W - 1) : CW'(c - 1);
      cr = (c == W - 1) ? CW'(0)     : CW'(c + 1);
      n  = 4'(above[cl]) + 4'(above[cc]) + 4'(above[cr]) +
           4'(cur[cl])                   + 4'(cur[cr])   +
           4'(below[cl]) + 4'(below[cc]) + 4'(below[cr]);
      life_row[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
    end
  endfunction

  state_t          state_r;
  state_t          state_n;
  logic [W-1:0]    rows_r [H];
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   ptr_r;
  logic [GW-1:0]   remaining_r;
  logic [W-1:0]    prev_r;
  logic [W-1:0]    row0_r;
  logic            change_r;
  logic [GW-1:0]   gen_r;
  logic            still_r;
  logic            done_r;

  logic            load_fire_s;
  logic            start_fire_s;
  logic [IW-1:0]   nxt_ptr_s;
  logic [W-1:0]    old_row_s;
  logic [W-1:0]    below_s;
  logic [W-1:0]    new_row_s;
  logic            row_change_s;

  assign load_ready   = (state_r != RUN);
  assign load_fire_s  = load_valid & (state_r != RUN);
  // A load handshake in the same cycle wins over start.
  assign start_fire_s = start & (state_r == IDLE) & ~load_fire_s;

  // Row below the one being computed; the last row wraps to the saved
  // copy of old row 0, because row 0 in the bank is already overwritten.
  assign nxt_ptr_s    = (ptr_r == LAST_ROW) ? IW'(0) : ptr_r + IW'(1);
  assign old_row_s    = rows_r[ptr_r];
  assign below_s      = (ptr_r == LAST_ROW) ? row0_r : rows_r[nxt_ptr_s];
  assign new_row_s    = life_row(prev_r, old_row_s, below_s);
  assign row_change_s = |(old_row_s ^ new_row_s);

  assign busy  = (state_r == RUN);
  assign done  = done_r;
  assign gen   = gen_r;
  assign still = still_r;

  // Flatten the row bank onto the grid output.
  for (genvar r = 0; r < H; r++) begin : g_flat
    assign grid[r*W +: W] = rows_r[r];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (load_fire_s) begin
          state_n = (idx_r == LAST_ROW) ? IDLE : LOAD;
        end else if (start_fire_s && (step_n != '0)) begin
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (load_fire_s && (idx_r == LAST_ROW)) begin
          state_n = IDLE;
        end else begin
          state_n = LOAD;
        end
      end
      RUN: begin
        if ((ptr_r == LAST_ROW) && (remaining_r == GW'(1))) begin
          state_n = IDLE;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Grid bank, load pointer, run bookkeeping and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < H; r++) begin
        rows_r[r] <= '0;
      end
      idx_r       <= '0;
      ptr_r       <= '0;
      remaining_r <= '0;
      prev_r      <= '0;
      row0_r      <= '0;
      change_r    <= 1'b0;
      gen_r       <= '0;
      still_r     <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_fire_s) begin
        rows_r[idx_r] <= load_row;
        idx_r         <= (idx_r == LAST_ROW) ? IW'(0) : idx_r + IW'(1);
        if (state_r == IDLE) begin
          gen_r   <= '0;
          still_r <= 1'b0;
        end
      end else if (start_fire_s) begin
        if (step_n == '0) begin
          done_r <= 1'b1;
        end else begin
          remaining_r <= step_n;
          ptr_r       <= '0;
          row0_r      <= rows_r[0];
          prev_r      <= rows_r[H-1];
          change_r    <= 1'b0;
        end
      end else if (state_r == RUN) begin
        rows_r[ptr_r] <= new_row_s;
        if (ptr_r == LAST_ROW) begin
          gen_r       <= gen_r + GW'(1);
          still_r     <= ~(change_r | row_change_s);
          change_r    <= 1'b0;
          remaining_r <= remaining_r - GW'(1);
          if (remaining_r == GW'(1)) begin
            done_r <= 1'b1;
          end else begin
            // Next generation: row 0 in the bank is the fresh one and the
            // new last row becomes the row above row 0.
            ptr_r  <= '0;
            row0_r <= rows_r[0];
            prev_r <= new_row_s;
          end
        end else begin
          change_r <= change_r | row_change_s;
          prev_r   <= old_row_s;
          ptr_r    <= ptr_r + IW'(1);
        end
      end
    end
  end

endmodule
